// File: rtl/quote_price_engine.sv
// Multi-symbol quote pricer: fixed-point ref/spread in, integer bid/ask out.
// Three register stages (capture, price, dedup/output) behind one global stall.
module quote_price_engine #(
  parameter int FP_WORD_SIZE = 64,
  parameter int FRAC_BITS    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_SYMBOLS  = 4,
  parameter int SYM_W        = $clog2(NUM_SYMBOLS),
  parameter int DEDUP_EN     = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [FP_WORD_SIZE-1:0] i_ref_price,
  input  logic [FP_WORD_SIZE-1:0] i_spread,
  input  logic [SYM_W-1:0]        i_symbol_id,
  input  logic                    i_data_valid,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_buy_price,
  output logic [DATA_WIDTH-1:0]   o_ask_price,
  output logic [SYM_W-1:0]        o_symbol_id,
  output logic                    o_data_valid,
  input  logic                    i_ready,
  output logic [CNT_W-1:0]        o_suppressed_count
);

  localparam int IW = FP_WORD_SIZE + 2;
  localparam int NT = 1 << SYM_W;
  localparam logic [IW-1:0]         RND  = IW'({FRAC_BITS{1'b1}});
  localparam logic [IW-1:0]         MAXW = IW'({DATA_WIDTH{1'b1}});
  localparam logic [DATA_WIDTH-1:0] PMAX = '1;
  localparam logic [CNT_W-1:0]      CMAX = '1;

  // [0] capture stage, [1] priced stage, [2] output register
  logic [2:0]                       vld_pipe;
  logic                             stall;
  logic                             sym_ok;
  logic                             dup;

  logic [FP_WORD_SIZE-1:0]          ref1, spr1;
  logic [SYM_W-1:0]                 sym1;
  logic [DATA_WIDTH-1:0]            bid2, ask2;
  logic [SYM_W-1:0]                 sym2;

  logic [NT-1:0]                    tbl_vld;
  logic [NT-1:0][DATA_WIDTH-1:0]    tbl_bid;
  logic [NT-1:0][DATA_WIDTH-1:0]    tbl_ask;

  logic [FP_WORD_SIZE-1:0]          half, bid_fp;
  logic [IW-1:0]                    ask_fp, bid_w, ask_w;
  logic [DATA_WIDTH-1:0]            bid_q, ask_q;

  assign stall        = o_data_valid && !i_ready;
  assign o_ready      = !stall;
  assign o_data_valid = vld_pipe[2];
  assign sym_ok       = {1'b0, i_symbol_id} < (SYM_W+1)'(NUM_SYMBOLS);

  // Bid floors, ask ceils (rounding constant folded into the wide add).
  always_comb begin
    half   = spr1 >> 1;
    bid_fp = (ref1 < half) ? '0 : ref1 - half;
    ask_fp = IW'(ref1) + IW'(half) + RND;
    bid_w  = IW'(bid_fp >> FRAC_BITS);
    ask_w  = ask_fp >> FRAC_BITS;
    bid_q  = (bid_w > MAXW) ? PMAX : bid_w[DATA_WIDTH-1:0];
    ask_q  = (ask_w > MAXW) ? PMAX : ask_w[DATA_WIDTH-1:0];
    if (ask_q <= bid_q) begin
      if (bid_q != PMAX) begin
        ask_q = bid_q + DATA_WIDTH'(1);
      end else begin
        bid_q = PMAX - DATA_WIDTH'(1);
        ask_q = PMAX;
      end
    end
  end

  assign dup = (DEDUP_EN != 0) && tbl_vld[sym2] &&
               (tbl_bid[sym2] == bid2) && (tbl_ask[sym2] == ask2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_pipe           <= '0;
      tbl_vld            <= '0;
      tbl_bid            <= '0;
      tbl_ask            <= '0;
      ref1               <= '0;
      spr1               <= '0;
      sym1               <= '0;
      bid2               <= '0;
      ask2               <= '0;
      sym2               <= '0;
      o_buy_price        <= '0;
      o_ask_price        <= '0;
      o_symbol_id        <= '0;
      o_suppressed_count <= '0;
    end else if (!stall) begin
      vld_pipe[0] <= i_data_valid && sym_ok;
      ref1        <= i_ref_price;
      spr1        <= i_spread;
      sym1        <= i_symbol_id;

      vld_pipe[1] <= vld_pipe[0];
      bid2        <= bid_q;
      ask2        <= ask_q;
      sym2        <= sym1;

      // Table compare and update share this stage so back-to-back beats see it.
      if (vld_pipe[1] && dup) begin
        vld_pipe[2] <= 1'b0;
        if (o_suppressed_count != CMAX)
          o_suppressed_count <= o_suppressed_count + CNT_W'(1);
      end else if (vld_pipe[1]) begin
        vld_pipe[2]   <= 1'b1;
        o_buy_price   <= bid2;
        o_ask_price   <= ask2;
        o_symbol_id   <= sym2;
        tbl_vld[sym2] <= 1'b1;
        tbl_bid[sym2] <= bid2;
        tbl_ask[sym2] <= ask2;
      end else begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quote_price_engine.sv
// Bench for quote_price_engine: directed test-plan steps plus random traffic
// scored against a price/dedup model that works on whole-number arithmetic.
module tb_quote_price_engine;

  typedef struct packed {
    logic [31:0] bid;
    logic [31:0] ask;
    logic [1:0]  sym;
  } quote_t;

  localparam logic [63:0] ONE = 64'h1_0000_0000;

  logic        clk = 0;
  logic        i_reset = 1;
  logic [63:0] i_ref_price = '0, i_spread = '0;
  logic [1:0]  i_symbol_id = '0;
  logic        i_data_valid = 0;
  logic        o_ready;
  logic [31:0] o_buy_price, o_ask_price;
  logic [1:0]  o_symbol_id;
  logic        o_data_valid;
  logic        i_ready = 1;
  logic [15:0] o_suppressed_count;

  // second instance: 3 symbols (so ID 3 is illegal), dedup disabled
  logic [63:0] b_ref = '0, b_spr = '0;
  logic [1:0]  b_sym = '0;
  logic        b_vld = 0, b_rdy = 1, b_oready, b_ovld;
  logic [31:0] b_buy, b_ask;
  logic [1:0]  b_osym;
  logic [15:0] b_cnt;

  int ncmp = 0, nfail = 0, n_out = 0;
  quote_t q[$];
  logic [3:0]  mv = '0;
  logic [31:0] mb [4], ma [4];
  int msup = 0;
  logic prev_stall = 0, prev_rst = 1;
  logic [65:0] prev_data = '0;
  bit got, done;

  always #5 clk = ~clk;

  quote_price_engine dut (
    .i_clk(clk), .i_reset(i_reset), .i_ref_price(i_ref_price), .i_spread(i_spread),
    .i_symbol_id(i_symbol_id), .i_data_valid(i_data_valid), .o_ready(o_ready),
    .o_buy_price(o_buy_price), .o_ask_price(o_ask_price), .o_symbol_id(o_symbol_id),
    .o_data_valid(o_data_valid), .i_ready(i_ready), .o_suppressed_count(o_suppressed_count)
  );

  quote_price_engine #(.NUM_SYMBOLS(3), .DEDUP_EN(0)) dut_nd (
    .i_clk(clk), .i_reset(i_reset), .i_ref_price(b_ref), .i_spread(b_spr),
    .i_symbol_id(b_sym), .i_data_valid(b_vld), .o_ready(b_oready),
    .o_buy_price(b_buy), .o_ask_price(b_ask), .o_symbol_id(b_osym),
    .o_data_valid(b_ovld), .i_ready(b_rdy), .o_suppressed_count(b_cnt)
  );

  // Quote rules evaluated on 128-bit integers: floor/ceil by division.
  function automatic void model_price(input logic [63:0] r, s,
                                      output logic [31:0] b, a);
    logic [127:0] h, bf, af, one, mx;
    one = 128'(ONE);
    mx  = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
    h   = 128'(s) / 2;
    bf  = (128'(r) >= h) ? (128'(r) - h) / one : 128'd0;
    af  = (128'(r) + h + one - 1) / one;
    if (bf > mx) bf = mx;
    if (af > mx) af = mx;
    if (af <= bf) begin
      if (bf < mx) af = bf + 1;
      else begin bf = mx - 1; af = mx; end
    end
    b = bf[31:0];
    a = af[31:0];
  endfunction

  function automatic void model_accept(input logic [63:0] r, s, input logic [1:0] sym);
    logic [31:0] b, a;
    model_price(r, s, b, a);
    if (mv[sym] && mb[sym] == b && ma[sym] == a) msup++;
    else begin
      q.push_back('{bid: b, ask: a, sym: sym});
      mv[sym] = 1'b1; mb[sym] = b; ma[sym] = a;
    end
  endfunction

  // Scoreboard and handshake checks, sampled on the falling edge.
  always @(negedge clk) begin
    logic stall_now;
    quote_t e;
    stall_now = o_data_valid && !i_ready;
    if (i_reset) begin
      q.delete(); mv = '0; msup = 0;
    end else begin
      if (prev_stall && !prev_rst) begin
        ncmp++;
        assert (o_data_valid === 1'b1 && {o_buy_price, o_ask_price, o_symbol_id} === prev_data)
          else begin nfail++; $error("FAIL stall_hold: got v=%0b %h want v=1 %h", o_data_valid,
            {o_buy_price, o_ask_price, o_symbol_id}, prev_data); end
      end
      ncmp++;
      assert (o_ready === !stall_now)
        else begin nfail++; $error("FAIL o_ready: got %b want %b", o_ready, !stall_now); end
      if (o_data_valid && i_ready) begin
        n_out++;
        ncmp++;
        if (q.size() == 0) begin
          nfail++;
          $error("FAIL unexpected_out: got bid=%h ask=%h sym=%0d want none",
                 o_buy_price, o_ask_price, o_symbol_id);
        end else begin
          e = q.pop_front();
          assert ({o_buy_price, o_ask_price, o_symbol_id} === e)
            else begin nfail++; $error("FAIL out_seq: got bid=%h ask=%h sym=%0d want bid=%h ask=%h sym=%0d",
              o_buy_price, o_ask_price, o_symbol_id, e.bid, e.ask, e.sym); end
        end
      end
      if (i_data_valid && o_ready) model_accept(i_ref_price, i_spread, i_symbol_id);
    end
    prev_stall = stall_now;
    prev_rst   = i_reset;
    prev_data  = {o_buy_price, o_ask_price, o_symbol_id};
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] r, s, input logic [1:0] sym);
    bit ok;
    ok = 0;
    i_ref_price = r; i_spread = s; i_symbol_id = sym; i_data_valid = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1; break; end
    end
    if (!ok) begin nfail++; ncmp++; $error("FAIL send_timeout: got o_ready=0 want 1"); end
    @(posedge clk); #1;
    i_data_valid = 0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] eb, ea, input logic [1:0] es);
    bit ok;
    ok = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_data_valid && i_ready) begin ok = 1; break; end
    end
    ncmp++;
    assert (ok) else begin nfail++; $error("FAIL %s_timeout: got no output want one", tag); end
    if (ok) begin
      ncmp++;
      assert ({o_buy_price, o_ask_price, o_symbol_id} === {eb, ea, es})
        else begin nfail++; $error("FAIL %s: got bid=%h ask=%h sym=%0d want bid=%h ask=%h sym=%0d",
          tag, o_buy_price, o_ask_price, o_symbol_id, eb, ea, es); end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    ncmp++;
    assert (q.size() == 0) else begin nfail++; $error("FAIL drain: got %0d pending want 0", q.size()); end
    idle(3);
  endtask

  task automatic check_cnt(input string tag, input int exp);
    @(negedge clk);
    ncmp++;
    assert (o_suppressed_count === 16'(exp))
      else begin nfail++; $error("FAIL %s: got %0d want %0d", tag, o_suppressed_count, exp); end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    i_reset = 1; idle(2); i_reset = 0;
  endtask

  task automatic send_b(input logic [63:0] r, s, input logic [1:0] sym);
    b_ref = r; b_spr = s; b_sym = sym; b_vld = 1;
    @(posedge clk); #1;
    b_vld = 0;
  endtask

  logic [63:0] vr [5] = '{64'h64_4000_0000, 64'h64_0000_0000, 64'h4000_0000,
                          64'hFFFF_FFFF_0000_0000, 64'h0};
  logic [63:0] vs [5] = '{64'h8000_0000, 64'h0, ONE, 64'h2_0000_0000, 64'h0};
  logic [1:0]  vy [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] vb [5] = '{32'd100, 32'd100, 32'd0, 32'hFFFF_FFFE, 32'd0};
  logic [31:0] va [5] = '{32'd101, 32'd101, 32'd1, 32'hFFFF_FFFF, 32'd1};

  initial begin
    int n0, cnt_b;
    logic [63:0] rr, ss;
    logic [31:0] lb, la;
    logic [1:0]  ls;

    // reset values
    idle(3); i_reset = 0;
    @(negedge clk);
    ncmp += 5;
    assert (o_data_valid === 1'b0) else begin nfail++; $error("FAIL rst_valid: got %b want 0", o_data_valid); end
    assert (o_buy_price === 32'd0) else begin nfail++; $error("FAIL rst_buy: got %h want 0", o_buy_price); end
    assert (o_ask_price === 32'd0) else begin nfail++; $error("FAIL rst_ask: got %h want 0", o_ask_price); end
    assert (o_symbol_id === 2'd0) else begin nfail++; $error("FAIL rst_sym: got %0d want 0", o_symbol_id); end
    assert (o_suppressed_count === 16'd0) else begin nfail++; $error("FAIL rst_cnt: got %0d want 0", o_suppressed_count); end
    @(posedge clk); #1;

    // latency: accepted in cycle N, visible in N+3 and not in N+2
    send(64'h64_8000_0000, ONE, 2'd0);
    @(posedge clk); #1;
    @(negedge clk);
    ncmp++;
    assert (o_data_valid === 1'b0) else begin nfail++; $error("FAIL lat_early: got %b want 0", o_data_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    ncmp++;
    assert (o_data_valid === 1'b1 && {o_buy_price, o_ask_price, o_symbol_id} === {32'd100, 32'd101, 2'd0})
      else begin nfail++; $error("FAIL lat_out: got v=%b bid=%h ask=%h want v=1 bid=64 ask=65",
        o_data_valid, o_buy_price, o_ask_price); end
    @(posedge clk); #1;

    // rounding, minimum spread, clamp, saturation
    for (int i = 0; i < 5; i++) begin
      send(vr[i], vs[i], vy[i]);
      wait_out($sformatf("vec%0d", i), vb[i], va[i], vy[i]);
    end
    drain();

    // dedup: sym1, sym2, sym1 identical -> two outputs, one suppressed
    reset_dut();
    n0 = n_out;
    send(64'h64_8000_0000, ONE, 2'd1);
    send(64'h64_8000_0000, ONE, 2'd2);
    send(64'h64_8000_0000, ONE, 2'd1);
    idle(8);
    ncmp++;
    assert (n_out - n0 == 2) else begin nfail++; $error("FAIL dedup_outs: got %0d want 2", n_out - n0); end
    check_cnt("dedup_cnt", 1);
    send(64'h65_8000_0000, ONE, 2'd1);
    wait_out("dedup_new", 32'd101, 32'd102, 2'd1);

    // dedup disabled instance, and an illegal symbol ID
    send_b(64'h64_8000_0000, ONE, 2'd3);
    cnt_b = 0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (b_ovld) cnt_b++; end
    @(posedge clk); #1;
    ncmp++;
    assert (cnt_b == 0) else begin nfail++; $error("FAIL bad_sym: got %0d outputs want 0", cnt_b); end
    send_b(64'h64_8000_0000, ONE, 2'd1);
    send_b(64'h64_8000_0000, ONE, 2'd2);
    send_b(64'h64_8000_0000, ONE, 2'd1);
    cnt_b = 0; lb = '0; la = '0; ls = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_ovld) begin cnt_b++; lb = b_buy; la = b_ask; ls = b_osym; end
    end
    @(posedge clk); #1;
    ncmp += 3;
    assert (cnt_b == 3) else begin nfail++; $error("FAIL nodedup_outs: got %0d want 3", cnt_b); end
    assert (b_cnt === 16'd0) else begin nfail++; $error("FAIL nodedup_cnt: got %0d want 0", b_cnt); end
    assert ({lb, la, ls} === {32'd100, 32'd101, 2'd1})
      else begin nfail++; $error("FAIL nodedup_last: got %h/%h/%0d want 64/65/1", lb, la, ls); end

    // backpressure: 6 beats, downstream holds off 4 cycles after first output
    reset_dut();
    n0 = n_out;
    i_ready = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(64'h10_0000_0000 + 64'(i) * ONE, ONE, 2'(i));
      end
      begin
        got = 0;
        for (int k = 0; k < 30; k++) begin @(negedge clk); if (o_data_valid) begin got = 1; break; end end
        repeat (4) @(negedge clk);
        ncmp++;
        assert (got && o_data_valid === 1'b1 && o_ready === 1'b0)
          else begin nfail++; $error("FAIL bp_hold: got v=%b rdy=%b want v=1 rdy=0", o_data_valid, o_ready); end
        @(posedge clk); #1;
        i_ready = 1;
      end
    join
    drain();
    ncmp++;
    assert (n_out - n0 == 6) else begin nfail++; $error("FAIL bp_count: got %0d want 6", n_out - n0); end

    // reset mid-stream: in-flight beats vanish, table is cleared
    reset_dut();
    send(64'h64_8000_0000, ONE, 2'd0);
    drain();
    send(64'h20_0000_0000, ONE, 2'd1);
    send(64'h21_0000_0000, ONE, 2'd2);
    i_ref_price = 64'h22_0000_0000; i_symbol_id = 2'd3; i_data_valid = 1; i_reset = 1;
    idle(1);
    i_data_valid = 0;
    idle(1);
    i_reset = 0;
    n0 = n_out;
    idle(8);
    ncmp++;
    assert (n_out == n0) else begin nfail++; $error("FAIL rst_flush: got %0d outputs want 0", n_out - n0); end
    send(64'h64_8000_0000, ONE, 2'd0);
    wait_out("rst_reemit", 32'd100, 32'd101, 2'd0);
    check_cnt("rst_cnt", 0);

    // random traffic with random downstream backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          case ($urandom_range(0, 3))
            0: rr = 64'h64_8000_0000;
            1: rr = 64'h65_8000_0000;
            default: rr = {$urandom, $urandom};
          endcase
          case ($urandom_range(0, 2))
            0: ss = ONE;
            1: ss = 64'h0;
            default: ss = {28'h0, 4'($urandom_range(0, 15)), $urandom};
          endcase
          send(rr, ss, 2'($urandom_range(0, 3)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1;
      end
    join
    drain();
    check_cnt("rand_cnt", msup);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
